// File: rtl/mod_cache_arbiter_if.sv
// mod_cache_arbiter_if
// Bundles requester A, requester B and cache-side signals of the cache arbiter.
// slave : arbiter view (receives requests, drives the cache).
// master: environment view (requesters plus the cache RAM).
interface mod_cache_arbiter_if;
   logic        a_req;
   logic        a_we;
   logic [15:0] a_addr;
   logic [15:0] a_wdata;
   logic        a_ack;
   logic        a_err;
   logic [15:0] a_rdata;

   logic        b_req;
   logic        b_we;
   logic [15:0] b_addr;
   logic [15:0] b_wdata;
   logic        b_ack;
   logic        b_err;
   logic [15:0] b_rdata;

   logic [15:0] cache_addr;
   logic [15:0] cache_dataIn;
   logic        cache_WE;
   logic [15:0] cache_dataOut;
   logic        busy;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      output a_ack, a_err, a_rdata,
      input  b_req, b_we, b_addr, b_wdata,
      output b_ack, b_err, b_rdata,
      output cache_addr, cache_dataIn, cache_WE,
      input  cache_dataOut,
      output busy
   );

   modport master (
      output a_req, a_we, a_addr, a_wdata,
      input  a_ack, a_err, a_rdata,
      output b_req, b_we, b_addr, b_wdata,
      input  b_ack, b_err, b_rdata,
      input  cache_addr, cache_dataIn, cache_WE,
      output cache_dataOut,
      input  busy
   );
endinterface

// File: rtl/mod_cache_arbiter.sv
// mod_cache_arbiter
// Shares a single-port 16-bit cache RAM between requesters A and B.
// Each access takes one IDLE (arbitration) cycle and one ACCESS cycle; the
// winner gets a one-cycle ack (plus err for out-of-range addresses).
// Optional build macro: CACHE_ARB_FIXED_PRIO_EN -- when defined, A always wins
// ties (round-robin disabled); otherwise ties alternate via last_grant.
module mod_cache_arbiter #(
   parameter int ADDR_WIDTH = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   mod_cache_arbiter_if.slave   bus
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   localparam logic GRANT_A = 1'b0;
   localparam logic GRANT_B = 1'b1;

   state_t      state_r;
   logic        last_grant_r;
   logic        winner_r;
   logic        valid_r;
   logic        read_r;
   logic        cache_we_r;
   logic [15:0] cache_addr_r;
   logic [15:0] cache_din_r;
   logic        a_ack_r;
   logic        b_ack_r;
   logic        a_err_r;
   logic        b_err_r;
   logic [15:0] a_rdata_r;
   logic [15:0] b_rdata_r;
   logic        busy_r;

   logic        a_elig_s;
   logic        b_elig_s;
   logic        grant_s;
   logic        pick_b_s;
   logic        sel_we_s;
   logic [15:0] sel_addr_s;
   logic [15:0] sel_wdata_s;

   // Address is valid only when every bit above the implemented range is zero.
   function automatic logic addr_in_range(input logic [15:0] addr);
      return ((addr >> ADDR_WIDTH) == 16'd0);
   endfunction

   // Eligibility, tie-break and request mux for the next grant.
   always_comb begin
      // A requester whose ack is high this cycle is still dropping req.
      a_elig_s = bus.a_req & ~a_ack_r;
      b_elig_s = bus.b_req & ~b_ack_r;
      grant_s  = a_elig_s | b_elig_s;
`ifdef CACHE_ARB_FIXED_PRIO_EN
      pick_b_s = b_elig_s & ~a_elig_s;
`else
      if (a_elig_s && b_elig_s) begin
         pick_b_s = (last_grant_r == GRANT_A);
      end else begin
         pick_b_s = b_elig_s;
      end
`endif
      if (pick_b_s) begin
         sel_we_s    = bus.b_we;
         sel_addr_s  = bus.b_addr;
         sel_wdata_s = bus.b_wdata;
      end else begin
         sel_we_s    = bus.a_we;
         sel_addr_s  = bus.a_addr;
         sel_wdata_s = bus.a_wdata;
      end
   end

   // Arbitration FSM: latch the winner in IDLE, complete and ack in ACCESS.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         last_grant_r <= GRANT_B;
         winner_r     <= GRANT_A;
         valid_r      <= 1'b0;
         read_r       <= 1'b0;
         cache_we_r   <= 1'b0;
         cache_addr_r <= 16'h0000;
         cache_din_r  <= 16'h0000;
         a_ack_r      <= 1'b0;
         b_ack_r      <= 1'b0;
         a_err_r      <= 1'b0;
         b_err_r      <= 1'b0;
         a_rdata_r    <= 16'h0000;
         b_rdata_r    <= 16'h0000;
         busy_r       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               a_ack_r <= 1'b0;
               b_ack_r <= 1'b0;
               a_err_r <= 1'b0;
               b_err_r <= 1'b0;
               if (grant_s) begin
                  winner_r     <= pick_b_s;
                  valid_r      <= addr_in_range(sel_addr_s);
                  read_r       <= ~sel_we_s;
                  cache_we_r   <= sel_we_s & addr_in_range(sel_addr_s);
                  cache_addr_r <= sel_addr_s;
                  cache_din_r  <= sel_wdata_s;
                  busy_r       <= 1'b1;
                  state_r      <= ACCESS;
               end else begin
                  state_r <= IDLE;
               end
            end
            ACCESS: begin
               if (winner_r == GRANT_A) begin
                  a_ack_r <= 1'b1;
                  a_err_r <= ~valid_r;
                  if (!valid_r) begin
                     a_rdata_r <= 16'h0000;
                  end else if (read_r) begin
                     a_rdata_r <= bus.cache_dataOut;
                  end else begin
                     a_rdata_r <= a_rdata_r;
                  end
               end else begin
                  b_ack_r <= 1'b1;
                  b_err_r <= ~valid_r;
                  if (!valid_r) begin
                     b_rdata_r <= 16'h0000;
                  end else if (read_r) begin
                     b_rdata_r <= bus.cache_dataOut;
                  end else begin
                     b_rdata_r <= b_rdata_r;
                  end
               end
               last_grant_r <= winner_r;
               cache_we_r   <= 1'b0;
               busy_r       <= 1'b0;
               state_r      <= IDLE;
            end
            default: begin
               cache_we_r <= 1'b0;
               busy_r     <= 1'b0;
               state_r    <= IDLE;
            end
         endcase
      end
   end

   // A reset arriving mid-access must never let the write commit.
   assign bus.cache_WE     = cache_we_r & ~rst;
   assign bus.cache_addr   = cache_addr_r;
   assign bus.cache_dataIn = cache_din_r;
   assign bus.a_ack        = a_ack_r;
   assign bus.b_ack        = b_ack_r;
   assign bus.a_err        = a_err_r;
   assign bus.b_err        = b_err_r;
   assign bus.a_rdata      = a_rdata_r;
   assign bus.b_rdata      = b_rdata_r;
   assign bus.busy         = busy_r;

endmodule

// File: tb/tb_mod_cache_arbiter.sv
// tb_mod_cache_arbiter
// Directed scenarios plus randomized two-requester traffic, checked against a
// transaction-level model (reference memory, per-port last read data).
module tb_mod_cache_arbiter;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   mod_cache_arbiter_if bus_if();

   mod_cache_arbiter #(.ADDR_WIDTH(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   // Cache RAM stub: combinational read, write on rising edge.
   logic [15:0] cache_mem [256];
   assign bus_if.cache_dataOut = cache_mem[bus_if.cache_addr[7:0]];

   // Commit cache writes.
   always @(posedge clk) begin
      if (bus_if.cache_WE) cache_mem[bus_if.cache_addr[7:0]] <= bus_if.cache_dataIn;
   end

   // Reference model state.
   logic [15:0] ref_mem [256];
   logic [15:0] exp_rdata [2];

   function automatic logic get_ack(input int p);
      return (p == 0) ? bus_if.a_ack : bus_if.b_ack;
   endfunction
   function automatic logic get_err(input int p);
      return (p == 0) ? bus_if.a_err : bus_if.b_err;
   endfunction
   function automatic logic [15:0] get_rdata(input int p);
      return (p == 0) ? bus_if.a_rdata : bus_if.b_rdata;
   endfunction

   task automatic drive_port(input int p, input logic req, input logic we,
                             input logic [15:0] addr, input logic [15:0] wd);
      if (p == 0) begin
         bus_if.a_req = req; bus_if.a_we = we; bus_if.a_addr = addr; bus_if.a_wdata = wd;
      end else begin
         bus_if.b_req = req; bus_if.b_we = we; bus_if.b_addr = addr; bus_if.b_wdata = wd;
      end
   endtask

   // Expected outcome of one completed access (15 implemented address bits).
   task automatic model_complete(input int p, input logic we, input logic [15:0] addr,
                                 input logic [15:0] wd, output logic err,
                                 output logic [15:0] rdata);
      err = (addr >= 16'h8000);
      if (err) rdata = 16'h0000;
      else if (we) begin
         ref_mem[addr[7:0]] = wd;
         rdata = exp_rdata[p];
      end else rdata = ref_mem[addr[7:0]];
      exp_rdata[p] = rdata;
   endtask

   // Issue one request and observe it until ack (bounded); no checking here.
   task automatic run_single(input int p, input logic we, input logic [15:0] addr,
                             input logic [15:0] wd, output int ack_at,
                             output int we_cycles, output logic err,
                             output logic [15:0] rdata);
      ack_at = -1; we_cycles = 0; err = 1'b0; rdata = 16'h0000;
      drive_port(p, 1'b1, we, addr, wd);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus_if.cache_WE) we_cycles++;
         if (get_ack(p)) begin
            ack_at = i; err = get_err(p); rdata = get_rdata(p);
            break;
         end
      end
      drive_port(p, 1'b0, 1'b0, 16'h0000, 16'h0000);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive_port(0, 1'b1, 1'b0, 16'h0001, 16'h0000);
      drive_port(1, 1'b1, 1'b0, 16'h0002, 16'h0000);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if ({bus_if.a_ack, bus_if.b_ack, bus_if.a_err, bus_if.b_err, bus_if.busy, bus_if.cache_WE} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ack/err/busy/we=%b expected 000000",
                     {bus_if.a_ack, bus_if.b_ack, bus_if.a_err, bus_if.b_err, bus_if.busy, bus_if.cache_WE});
         end
         n_checks++;
         if ({bus_if.a_rdata, bus_if.b_rdata, bus_if.cache_addr, bus_if.cache_dataIn} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0",
                     {bus_if.a_rdata, bus_if.b_rdata, bus_if.cache_addr, bus_if.cache_dataIn});
         end
      end
      @(negedge clk);
      drive_port(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      drive_port(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      rst = 1'b0;
      exp_rdata[0] = 16'h0000; exp_rdata[1] = 16'h0000;
   endtask

   task automatic test_alternate();
      logic        err;
      logic [15:0] rd;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_rdata[0] = 16'h0000; exp_rdata[1] = 16'h0000;
      drive_port(0, 1'b1, 1'b0, 16'h0003, 16'h0000);
      drive_port(1, 1'b1, 1'b0, 16'h0004, 16'h0000);
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         n_checks++;
         if ({bus_if.a_ack, bus_if.b_ack, bus_if.busy} !== {(n % 4) == 1, (n % 4) == 3, (n % 2) == 0}) begin
            n_fail++;
            $display("FAIL alternate_seq cycle %0d: got a_ack,b_ack,busy=%b%b%b expected %b%b%b", n,
                     bus_if.a_ack, bus_if.b_ack, bus_if.busy, (n % 4) == 1, (n % 4) == 3, (n % 2) == 0);
         end
         for (int p = 0; p < 2; p++) begin
            if (get_ack(p)) begin
               model_complete(p, 1'b0, (p == 0) ? 16'h0003 : 16'h0004, 16'h0000, err, rd);
               n_checks++;
               if (get_rdata(p) !== rd) begin
                  n_fail++;
                  $display("FAIL alternate_rdata port %0d: got %h expected %h", p, get_rdata(p), rd);
               end
            end
         end
      end
      drive_port(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      drive_port(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
   endtask

   task automatic test_write_read();
      int ack_at, wec;
      logic err, exp_err;
      logic [15:0] rd, exp_rd;
      @(negedge clk);
      run_single(0, 1'b1, 16'h0010, 16'hBEEF, ack_at, wec, err, rd);
      model_complete(0, 1'b1, 16'h0010, 16'hBEEF, exp_err, exp_rd);
      n_checks++;
      if (ack_at !== 1 || wec !== 1) begin
         n_fail++;
         $display("FAIL write_timing: got ack_at=%0d we_cycles=%0d expected 1/1", ack_at, wec);
      end
      n_checks++;
      if (err !== exp_err || rd !== exp_rd) begin
         n_fail++;
         $display("FAIL write_result: got err=%b rdata=%h expected %b/%h", err, rd, exp_err, exp_rd);
      end
      @(negedge clk);
      run_single(0, 1'b0, 16'h0010, 16'h0000, ack_at, wec, err, rd);
      model_complete(0, 1'b0, 16'h0010, 16'h0000, exp_err, exp_rd);
      n_checks++;
      if (ack_at !== 1 || wec !== 0) begin
         n_fail++;
         $display("FAIL read_timing: got ack_at=%0d we_cycles=%0d expected 1/0", ack_at, wec);
      end
      n_checks++;
      if (err !== 1'b0 || rd !== 16'hBEEF || rd !== exp_rd) begin
         n_fail++;
         $display("FAIL read_back: got err=%b rdata=%h expected 0/beef", err, rd);
      end
   endtask

   task automatic test_out_of_range();
      int ack_at, wec;
      logic err, exp_err;
      logic [15:0] rd, exp_rd;
      @(negedge clk);
      run_single(1, 1'b1, 16'h8000, 16'h1234, ack_at, wec, err, rd);
      model_complete(1, 1'b1, 16'h8000, 16'h1234, exp_err, exp_rd);
      n_checks++;
      if (ack_at !== 1 || wec !== 0) begin
         n_fail++;
         $display("FAIL oor_timing: got ack_at=%0d we_cycles=%0d expected 1/0", ack_at, wec);
      end
      n_checks++;
      if (err !== 1'b1 || rd !== 16'h0000 || err !== exp_err || rd !== exp_rd) begin
         n_fail++;
         $display("FAIL oor_result: got err=%b rdata=%h expected 1/0000", err, rd);
      end
      @(negedge clk);
      n_checks++;
      if ({bus_if.b_ack, bus_if.b_err} !== 2'b00) begin
         n_fail++;
         $display("FAIL oor_pulse: got b_ack,b_err=%b%b expected 00", bus_if.b_ack, bus_if.b_err);
      end
      run_single(1, 1'b0, 16'h0000, 16'h0000, ack_at, wec, err, rd);
      model_complete(1, 1'b0, 16'h0000, 16'h0000, exp_err, exp_rd);
      n_checks++;
      if (ack_at !== 1 || err !== 1'b0 || rd !== exp_rd) begin
         n_fail++;
         $display("FAIL oor_readback: got ack_at=%0d err=%b rdata=%h expected 1/0/%h", ack_at, err, rd, exp_rd);
      end
   endtask

   task automatic test_reset_during_access();
      int ack_at, wec;
      logic err, exp_err;
      logic [15:0] rd, exp_rd, prev;
      prev = ref_mem[8'h20];
      @(negedge clk);
      drive_port(0, 1'b1, 1'b1, 16'h0020, 16'hCAFE);
      @(negedge clk);
      n_checks++;
      if (bus_if.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_access_busy: got %b expected 1", bus_if.busy);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (bus_if.cache_WE !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_access_we: got %b expected 0", bus_if.cache_WE);
      end
      @(negedge clk);
      n_checks++;
      if ({bus_if.a_ack, bus_if.busy} !== 2'b00 || cache_mem[8'h20] !== prev) begin
         n_fail++;
         $display("FAIL rst_access_abandon: got ack,busy=%b%b mem=%h expected 00/%h",
                  bus_if.a_ack, bus_if.busy, cache_mem[8'h20], prev);
      end
      rst = 1'b0;
      exp_rdata[0] = 16'h0000; exp_rdata[1] = 16'h0000;
      run_single(0, 1'b1, 16'h0020, 16'hCAFE, ack_at, wec, err, rd);
      model_complete(0, 1'b1, 16'h0020, 16'hCAFE, exp_err, exp_rd);
      n_checks++;
      if (ack_at !== 1 || wec !== 1 || err !== exp_err || rd !== exp_rd) begin
         n_fail++;
         $display("FAIL rst_access_retry: got ack_at=%0d we=%0d err=%b rdata=%h expected 1/1/%b/%h",
                  ack_at, wec, err, rd, exp_err, exp_rd);
      end
      n_checks++;
      if (cache_mem[8'h20] !== 16'hCAFE) begin
         n_fail++;
         $display("FAIL rst_access_mem: got %h expected cafe", cache_mem[8'h20]);
      end
   endtask

   task automatic test_back_to_back();
      logic err;
      logic [15:0] rd;
      @(negedge clk);
      drive_port(0, 1'b1, 1'b0, 16'h0005, 16'h0000);
      @(negedge clk);
      drive_port(1, 1'b1, 1'b0, 16'h0006, 16'h0000);
      @(negedge clk);
      model_complete(0, 1'b0, 16'h0005, 16'h0000, err, rd);
      n_checks++;
      if (bus_if.a_ack !== 1'b1 || bus_if.a_rdata !== rd) begin
         n_fail++;
         $display("FAIL b2b_a_ack: got ack=%b rdata=%h expected 1/%h", bus_if.a_ack, bus_if.a_rdata, rd);
      end
      @(negedge clk);
      n_checks++;
      if ({bus_if.busy, bus_if.a_ack} !== 2'b10) begin
         n_fail++;
         $display("FAIL b2b_grant_b: got busy,a_ack=%b%b expected 10", bus_if.busy, bus_if.a_ack);
      end
      drive_port(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      @(negedge clk);
      model_complete(1, 1'b0, 16'h0006, 16'h0000, err, rd);
      n_checks++;
      if ({bus_if.b_ack, bus_if.a_ack} !== 2'b10 || bus_if.b_rdata !== rd) begin
         n_fail++;
         $display("FAIL b2b_b_ack: got b_ack,a_ack=%b%b rdata=%h expected 10/%h",
                  bus_if.b_ack, bus_if.a_ack, bus_if.b_rdata, rd);
      end
      drive_port(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      @(negedge clk);
      n_checks++;
      if ({bus_if.busy, bus_if.a_ack, bus_if.b_ack} !== 3'b000) begin
         n_fail++;
         $display("FAIL b2b_no_regrant: got busy,a_ack,b_ack=%b%b%b expected 000",
                  bus_if.busy, bus_if.a_ack, bus_if.b_ack);
      end
   endtask

   task automatic test_random(input int ncyc);
      logic        active [2];
      int          waited [2];
      logic        r_we   [2];
      logic [15:0] r_addr [2];
      logic [15:0] r_wd   [2];
      logic        err;
      logic [15:0] rd;
      active[0] = 1'b0; active[1] = 1'b0;
      waited[0] = 0;    waited[1] = 0;
      for (int cyc = 0; cyc < ncyc + 10; cyc++) begin
         @(negedge clk);
         n_checks++;
         if ((bus_if.a_ack && bus_if.b_ack) || (bus_if.cache_WE && !bus_if.busy)) begin
            n_fail++;
            $display("FAIL rand_exclusive cycle %0d: got a_ack,b_ack,we,busy=%b%b%b%b",
                     cyc, bus_if.a_ack, bus_if.b_ack, bus_if.cache_WE, bus_if.busy);
         end
         for (int p = 0; p < 2; p++) begin
            if (active[p] && get_ack(p)) begin
               model_complete(p, r_we[p], r_addr[p], r_wd[p], err, rd);
               n_checks++;
               if (get_err(p) !== err || get_rdata(p) !== rd) begin
                  n_fail++;
                  $display("FAIL rand_result port %0d addr %h we %b: got err=%b rdata=%h expected %b/%h",
                           p, r_addr[p], r_we[p], get_err(p), get_rdata(p), err, rd);
               end
               active[p] = 1'b0;
               drive_port(p, 1'b0, 1'b0, 16'h0000, 16'h0000);
            end else if (active[p]) begin
               waited[p]++;
               n_checks++;
               if (waited[p] > 3 || get_rdata(p) !== exp_rdata[p]) begin
                  n_fail++;
                  $display("FAIL rand_wait port %0d: got waited=%0d rdata=%h expected <=3/%h",
                           p, waited[p], get_rdata(p), exp_rdata[p]);
               end
            end else begin
               n_checks++;
               if (get_ack(p) !== 1'b0 || get_rdata(p) !== exp_rdata[p]) begin
                  n_fail++;
                  $display("FAIL rand_idle port %0d: got ack=%b rdata=%h expected 0/%h",
                           p, get_ack(p), get_rdata(p), exp_rdata[p]);
               end
               if (cyc < ncyc && $urandom_range(2, 0) == 0) begin
                  r_we[p]   = 1'($urandom_range(1, 0));
                  r_addr[p] = ($urandom_range(7, 0) == 0) ? (16'h8000 | 16'($urandom))
                                                          : 16'($urandom_range(15, 0));
                  r_wd[p]   = 16'($urandom);
                  waited[p] = 0;
                  active[p] = 1'b1;
                  drive_port(p, 1'b1, r_we[p], r_addr[p], r_wd[p]);
               end
            end
         end
         if (cyc >= ncyc && !active[0] && !active[1]) break;
      end
      n_checks++;
      if (active[0] || active[1]) begin
         n_fail++;
         $display("FAIL rand_drain: got active=%b%b expected 00", active[0], active[1]);
      end
   endtask

   // Hard stop in case a test never returns.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         cache_mem[i] = 16'(i * 16'h0103) ^ 16'h5A5A;
         ref_mem[i]   = 16'(i * 16'h0103) ^ 16'h5A5A;
      end
      exp_rdata[0] = 16'h0000;
      exp_rdata[1] = 16'h0000;
      test_reset();
      test_alternate();
      test_write_read();
      test_out_of_range();
      test_reset_during_access();
      test_back_to_back();
      test_random(600);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
